// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: evaluates ALU flags, registers redirect/flush on mispredict, owns the 2-bit BHT.
// Optional perf counters (branch_count_o, mispredict_count_o) are built when BRU_PERF_COUNTERS_EN is defined.
module branch_resolve_unit #(
    parameter int BHT_ENTRIES = 16,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            is_branch_i,
    input  logic [2:0]      funct3_i,
    input  logic [3:0]      status_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            predicted_taken_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            predict_taken_o,
    output logic            valid_o,
    output logic            taken_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o
`ifdef BRU_PERF_COUNTERS_EN
    ,
    output logic [31:0]     branch_count_o,
    output logic [31:0]     mispredict_count_o
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {RUN, SQUASH} state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    // status = {n, z, c, v} of rs1 - rs2; c=1 means rs1 >= rs2 unsigned
    function automatic logic cond_eval(input logic [2:0] f3, input logic [3:0] st);
        logic n, z, c, v;
        {n, z, c, v} = st;
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n ^ v;
            3'b101:  return !(n ^ v);
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic tk);
        if (tk)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic            taken_q, taken_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [1:0]      bht_q [BHT_ENTRIES];

    logic            cond, accept, mis_now;
    logic [XLEN-1:0] pc_plus4;
    logic [IDX_W-1:0] upd_idx, lkp_idx;

    assign cond     = cond_eval(funct3_i, status_i);
    assign accept   = valid_i && is_branch_i && f3_legal(funct3_i) && !stall_i && (state_q == RUN);
    assign mis_now  = cond ^ predicted_taken_i;
    assign pc_plus4 = pc_i + XLEN'(4);
    assign upd_idx  = pc_i[IDX_W+1:2];
    assign lkp_idx  = lookup_pc_i[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[XLEN-1:IDX_W+2], pc_i[1:0],
                              lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0]};

    // Lookup reads the registered array, so a same-cycle update is not yet visible
    assign predict_taken_o = bht_q[lkp_idx][1];

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        taken_d = taken_q;
        mis_d   = mis_q;
        redir_d = redir_q;
        if (!stall_i) begin
            valid_d = accept;
            mis_d   = accept && mis_now;
            if (accept) begin
                taken_d = cond;
                redir_d = cond ? target_i : pc_plus4;
            end
            case (state_q)
                RUN:     state_d = (accept && mis_now) ? SQUASH : RUN;
                SQUASH:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
            redir_q <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht_q[i] <= 2'b01;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
            redir_q <= redir_d;
            if (accept)
                bht_q[upd_idx] <= ctr_update(bht_q[upd_idx], cond);
        end
    end

    assign valid_o       = valid_q;
    assign taken_o       = taken_q;
    assign mispredict_o  = mis_q;
    assign flush_o       = mis_q;
    assign redirect_pc_o = redir_q;

`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] br_cnt_q, mis_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (accept && (br_cnt_q != 32'hFFFF_FFFF))
                br_cnt_q <= br_cnt_q + 32'd1;
            if (accept && mis_now && (mis_cnt_q != 32'hFFFF_FFFF))
                mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign branch_count_o     = br_cnt_q;
    assign mispredict_count_o = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; perf counter checks build with BRU_PERF_COUNTERS_EN.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, is_branch_i, predicted_taken_i, stall_i;
    logic [2:0]  funct3_i;
    logic [3:0]  status_i;
    logic [31:0] pc_i, target_i, lookup_pc_i;
    logic        predict_taken_o, valid_o, taken_o, mispredict_o, flush_o;
    logic [31:0] redirect_pc_o;
`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] branch_count_o, mispredict_count_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.BHT_ENTRIES(16), .XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_i           (valid_i),
        .is_branch_i       (is_branch_i),
        .funct3_i          (funct3_i),
        .status_i          (status_i),
        .pc_i              (pc_i),
        .target_i          (target_i),
        .predicted_taken_i (predicted_taken_i),
        .stall_i           (stall_i),
        .lookup_pc_i       (lookup_pc_i),
        .predict_taken_o   (predict_taken_o),
        .valid_o           (valid_o),
        .taken_o           (taken_o),
        .mispredict_o      (mispredict_o),
        .redirect_pc_o     (redirect_pc_o),
        .flush_o           (flush_o)
`ifdef BRU_PERF_COUNTERS_EN
        ,
        .branch_count_o    (branch_count_o),
        .mispredict_count_o(mispredict_count_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [3:0] st, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred);
        valid_i           = 1'b1;
        is_branch_i       = 1'b1;
        funct3_i          = f3;
        status_i          = st;
        pc_i              = pc;
        target_i          = tgt;
        predicted_taken_i = pred;
    endtask

    task automatic idle();
        valid_i     = 1'b0;
        is_branch_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic tk, input logic m,
                              input logic [31:0] rpc);
        check({tag, ".valid"}, 32'(valid_o), 32'(v));
        check({tag, ".taken"}, 32'(taken_o), 32'(tk));
        check({tag, ".mis"},   32'(mispredict_o), 32'(m));
        check({tag, ".flush"}, 32'(flush_o), 32'(m));
        check({tag, ".rpc"},   redirect_pc_o, rpc);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; is_branch_i = 1'b0; funct3_i = 3'b000; status_i = 4'b0000;
        pc_i = 32'h0; target_i = 32'h0; predicted_taken_i = 1'b0; stall_i = 1'b0;
        lookup_pc_i = 32'h100;
        do_reset();

        expect_out("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        #1 check("reset.pred100", 32'(predict_taken_o), 32'd0);

        // Non-branch valid instruction produces no result
        valid_i = 1'b1; is_branch_i = 1'b0;
        step();
        idle();
        check("nonbr.valid", 32'(valid_o), 32'd0);
        check("nonbr.flush", 32'(flush_o), 32'd0);

        // BEQ taken, predicted not-taken -> mispredict, then wrong-path instruction dropped
        drive(3'b000, 4'b0100, 32'h40, 32'h80, 1'b0);
        step();
        expect_out("beq", 1'b1, 1'b1, 1'b1, 32'h80);
        drive(3'b000, 4'b0100, 32'h40, 32'h80, 1'b0);
        step();
        idle();
        check("squash.valid", 32'(valid_o), 32'd0);
        check("squash.mis", 32'(mispredict_o), 32'd0);
        lookup_pc_i = 32'h40;
        #1 check("squash.noupd", 32'(predict_taken_o), 32'd1);

        // Condition table: BLT, BLTU, BGEU, BGE, BNE, illegal funct3
        drive(3'b100, 4'b1001, 32'h10, 32'h20, 1'b0);
        step();
        expect_out("blt", 1'b1, 1'b0, 1'b0, 32'h14);
        drive(3'b110, 4'b0010, 32'h18, 32'h30, 1'b0);
        step();
        expect_out("bltu", 1'b1, 1'b0, 1'b0, 32'h1C);
        drive(3'b111, 4'b0010, 32'h20, 32'h60, 1'b1);
        step();
        expect_out("bgeu", 1'b1, 1'b1, 1'b0, 32'h60);
        drive(3'b101, 4'b1000, 32'h24, 32'h70, 1'b1);
        step();
        expect_out("bge", 1'b1, 1'b0, 1'b1, 32'h28);
        idle();
        step();
        drive(3'b010, 4'b0100, 32'h30, 32'h90, 1'b1);
        step();
        idle();
        check("illegal.valid", 32'(valid_o), 32'd0);

        // BHT saturation at pc 0x40 from a fresh reset
        do_reset();
        lookup_pc_i = 32'h40;
        drive(3'b001, 4'b0000, 32'h40, 32'h100, 1'b1);
        #1 check("bht.preupd", 32'(predict_taken_o), 32'd0);
        step();
        check("bht.t1", 32'(predict_taken_o), 32'd1);
        check("bne.taken", 32'(taken_o), 32'd1);
        step();
        step();
        check("bht.t3", 32'(predict_taken_o), 32'd1);
        drive(3'b001, 4'b0100, 32'h40, 32'h100, 1'b0);
        step();
        check("bht.nt1", 32'(predict_taken_o), 32'd1);
        step();
        idle();
        check("bht.nt2", 32'(predict_taken_o), 32'd0);
        check("bne.nt", 32'(taken_o), 32'd0);

        // Not-taken mispredict at top of address space wraps, held under stall
        drive(3'b000, 4'b0000, 32'hFFFF_FFFC, 32'h200, 1'b1);
        step();
        expect_out("wrap", 1'b1, 1'b0, 1'b1, 32'h0);
        stall_i = 1'b1;
        drive(3'b000, 4'b0100, 32'h100, 32'h300, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("stall", 1'b1, 1'b0, 1'b1, 32'h0);
        end
        stall_i = 1'b0;
        step();
        check("unstall.drop", 32'(valid_o), 32'd0);
        step();
        idle();
        expect_out("after", 1'b1, 1'b1, 1'b1, 32'h300);

        // Reset overrides stall and a pending mispredict
        stall_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall_i = 1'b0;
        expect_out("midrst", 1'b0, 1'b0, 1'b0, 32'h0);

`ifdef BRU_PERF_COUNTERS_EN
        do_reset();
        drive(3'b100, 4'b1001, 32'h10, 32'h20, 1'b0);
        step();
        drive(3'b110, 4'b0010, 32'h18, 32'h30, 1'b0);
        step();
        drive(3'b000, 4'b0100, 32'h40, 32'h80, 1'b0);
        step();
        idle();
        step();
        drive(3'b111, 4'b0010, 32'h20, 32'h60, 1'b1);
        step();
        drive(3'b000, 4'b0000, 32'h44, 32'h90, 1'b1);
        step();
        idle();
        step();
        check("perf.br", branch_count_o, 32'd5);
        check("perf.mis", mispredict_count_o, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("perf.rst.br", branch_count_o, 32'd0);
        check("perf.rst.mis", mispredict_count_o, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage consumer of the ALU status flags. The ALU computes rs1 - rs2 (SUB) for each conditional branch, and this block turns its {n,z,c,v} status into a taken/not-taken decision. It compares that decision with the fetch-stage prediction and issues a registered redirect/flush on mispredict. It also owns the 2-bit saturating branch history table (BHT) that fetch queries for predictions.

Parameters:
BHT_ENTRIES, 16, number of 2-bit counters; power of two, >= 2
XLEN, 32, PC/address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  execute-stage instruction valid
is_branch_i  in  1  instruction is a conditional branch (B-type)
funct3_i  in  3  branch funct3
status_i  in  4  ALU status of rs1 - rs2: [3]=n [2]=z [1]=c [0]=v
pc_i  in  XLEN  branch PC
target_i  in  XLEN  branch target (pc + imm)
predicted_taken_i  in  1  prediction carried down from fetch
stall_i  in  1  pipeline stall; hold all state
lookup_pc_i  in  XLEN  fetch PC for prediction lookup
predict_taken_o  out  1  BHT prediction for lookup_pc_i (combinational)
valid_o  out  1  resolved-branch result valid
taken_o  out  1  resolved direction
mispredict_o  out  1  resolved direction != prediction
redirect_pc_o  out  XLEN  correct next PC when mispredict_o=1
flush_o  out  1  squash younger stages; equals mispredict_o

Behaviour:
- One clock: clk. rst is synchronous, active-high.
- Carry convention: c = carry-out of rs1 + ~rs2 + 1, so c=1 means rs1 >= rs2 unsigned.
- Condition table:
  - BEQ 000: z
  - BNE 001: !z
  - BLT 100: n^v
  - BGE 101: !(n^v)
  - BLTU 110: !c
  - BGEU 111: c
  - 010/011: illegal; the instruction is treated as a non-branch.
- Accept condition: valid_i & is_branch_i & legal funct3 & !stall_i & state==RUN.
- Latency is 1 cycle. On accept, the next cycle shows:
  - valid_o=1, taken_o=condition.
  - mispredict_o = condition ^ predicted_taken_i.
  - redirect_pc_o = condition ? target_i : pc_i + 4 (modulo 2^XLEN; wraps at 0xFFFF_FFFC).
- Non-accepted cycle with !stall_i: valid_o=0, mispredict_o=0, flush_o=0. redirect_pc_o holds its last value.
- stall_i=1: every register (outputs, FSM, BHT) holds. A pulse already on valid_o/mispredict_o stays asserted until the first unstalled cycle.
- FSM states:
  - RUN -> SQUASH when a mispredict is registered.
  - SQUASH -> RUN after one unstalled cycle.
  - In SQUASH, valid_i is ignored: the wrong-path instruction is dropped and no BHT update occurs.
- BHT:
  - BHT_ENTRIES 2-bit counters.
  - Index = pc[$clog2(BHT_ENTRIES)+1:2].
  - Update on accept: taken increments and saturates at 11; not-taken decrements and saturates at 00.
  - predict_taken_o = counter[lookup index][1].
  - Same-index lookup and update in one cycle: the lookup returns the pre-update value.
- Reset values:
  - valid_o, taken_o, mispredict_o, flush_o = 0.
  - redirect_pc_o = 0.
  - FSM = RUN.
  - All counters = 01 (weakly not-taken).
  - Reset asserted mid-operation overrides stall and any pending mispredict.

Optional Feature:
BRU_PERF_COUNTERS_EN
- Defined: adds outputs branch_count_o[31:0] and mispredict_count_o[31:0].
  - branch_count_o increments on every accept.
  - mispredict_count_o increments on every registered mispredict.
  - Both saturate at 0xFFFF_FFFF, reset to 0 and hold under stall.
- Undefined: the ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then lookup_pc_i=0x100 -> predict_taken_o=0. One cycle after a non-branch valid_i: valid_o=0, flush_o=0.
- BEQ at pc=0x40, target=0x80, status=0100, predicted_taken=0 -> next cycle:
  - valid_o=1, taken_o=1, mispredict_o=1, flush_o=1, redirect_pc_o=0x80.
  - A valid_i presented in that cycle is dropped (valid_o=0 one cycle later).
- BLT with n=1,v=1 and BLTU with c=1, each predicted 0 -> taken_o=0, mispredict_o=0. BGEU with c=1, predicted 1 -> taken_o=1, mispredict_o=0.
- Three taken BNE at pc=0x40 -> counter 01→10→11→11; predict_taken_o for lookup 0x40 = 1 after the first update. Two not-taken -> counter 01, prediction 0.
- Not-taken mispredict at pc=0xFFFF_FFFC, predicted 1 -> redirect_pc_o=0x0000_0000. Stall held 3 cycles during the result -> mispredict_o stays high, and a second valid_i is not accepted until stall_i drops.
- With BRU_PERF_COUNTERS_EN: 5 accepted branches with 2 mispredicts -> branch_count_o=5, mispredict_count_o=2. rst -> both 0.
